// File: rtl/wb_cpu_bridge_pkg.sv
// Shared types and constants for the 6502-to-Wishbone bridge and its helpers.
package wb_cpu_bridge_pkg;

  // Which Wishbone slave a CPU access is routed to.
  typedef enum logic [1:0] {
    SEL_TIA  = 2'd0,
    SEL_RIOT = 2'd1,
    SEL_ROM  = 2'd2
  } sel_t;

  // Bridge FSM state encoding, kept as plain constants for legacy tools.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Address bits that carve the 8K Atari map into ROM / RIOT / TIA.
  localparam int ROM_BIT  = 12;
  localparam int RIOT_BIT = 7;

  // Data handed back to the CPU when a read gets no ack.
  localparam logic [7:0] RD_TIMEOUT_VAL = 8'hFF;

  // A12 selects the cartridge; below that, A7 splits RIOT from TIA.
  function automatic sel_t decode_sel(input logic a_rom, input logic a_riot);
    sel_t sel;
    if (a_rom) begin
      sel = SEL_ROM;
    end else if (a_riot) begin
      sel = SEL_RIOT;
    end else begin
      sel = SEL_TIA;
    end
    return sel;
  endfunction

endpackage

// File: rtl/wb_cpu_bridge_if.sv
// CPU-side request bus and Wishbone slave bus seen by the bridge.
interface wb_cpu_bridge_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8
) ();
  import wb_cpu_bridge_pkg::*;

  // CPU side
  logic                  cpu_req;
  logic [15:0]           cpu_addr;
  logic                  cpu_we;
  logic [DATA_WIDTH-1:0] cpu_dout;
  logic [DATA_WIDTH-1:0] cpu_din;
  logic                  cpu_done;
  logic                  stall_i;

  // Wishbone side
  logic [ADDR_WIDTH-1:0] adr_o;
  logic [DATA_WIDTH-1:0] dat_o;
  logic                  we_o;
  logic                  stb_tia_o;
  logic                  stb_riot_o;
  logic                  stb_rom_o;
  logic                  ack_tia_i;
  logic                  ack_riot_i;
  logic                  ack_rom_i;
  logic [DATA_WIDTH-1:0] dat_tia_i;
  logic [DATA_WIDTH-1:0] dat_riot_i;
  logic [DATA_WIDTH-1:0] dat_rom_i;
  logic                  bus_err_o;

  // Bridge view.
  modport master (
    input  cpu_req, cpu_addr, cpu_we, cpu_dout, stall_i,
    input  ack_tia_i, ack_riot_i, ack_rom_i, dat_tia_i, dat_riot_i, dat_rom_i,
    output cpu_din, cpu_done,
    output adr_o, dat_o, we_o, stb_tia_o, stb_riot_o, stb_rom_o, bus_err_o
  );

  // CPU / slave environment view.
  modport slave (
    output cpu_req, cpu_addr, cpu_we, cpu_dout, stall_i,
    output ack_tia_i, ack_riot_i, ack_rom_i, dat_tia_i, dat_riot_i, dat_rom_i,
    input  cpu_din, cpu_done,
    input  adr_o, dat_o, we_o, stb_tia_o, stb_riot_o, stb_rom_o, bus_err_o
  );

endinterface

// File: rtl/wb_cpu_bridge_addr_decode.sv
// Combinational 13-bit Atari address to slave-select decoder; also usable
// by a passive bus monitor.
module wb_addr_decode
  import wb_cpu_bridge_pkg::*;
(
  input  logic [12:0] i_addr,
  output sel_t        o_sel
);

  // Only A12 and A7 matter; the remaining bits are mirror/offset bits.
  logic w_unused_addr;
  assign w_unused_addr = ^{i_addr[11:8], i_addr[6:0]};

  assign o_sel = decode_sel(i_addr[ROM_BIT], i_addr[RIOT_BIT]);

endmodule

// File: rtl/wb_cpu_bridge.sv
// Wishbone master between the 6502 core and the TIA / RIOT / ROM slaves.
// One request in flight; completion is a single-cycle cpu_done pulse.
module wb_cpu_bridge
  import wb_cpu_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  wb_cpu_bridge_if.master  bus
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t                r_state;
  sel_t                  r_sel;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [DATA_WIDTH-1:0] r_dat;
  logic                  r_we;
  logic                  r_stb_tia;
  logic                  r_stb_riot;
  logic                  r_stb_rom;
  logic [DATA_WIDTH-1:0] r_din;
  logic                  r_done;
  logic                  r_err;

  sel_t                  w_sel;
  logic                  w_ack;
  logic [DATA_WIDTH-1:0] w_rdata;

  // Mirror bits above A12 are ignored by the console.
  logic w_unused_addr_hi;
  assign w_unused_addr_hi = ^bus.cpu_addr[15:13];

  wb_addr_decode u_decode (
    .i_addr (bus.cpu_addr[12:0]),
    .o_sel  (w_sel)
  );

  // Pick the ack and read data of the slave latched for this transaction.
  always_comb begin
    w_ack   = 1'b0;
    w_rdata = '0;
    case (r_sel)
      SEL_TIA: begin
        w_ack   = bus.ack_tia_i;
        w_rdata = bus.dat_tia_i;
      end
      SEL_RIOT: begin
        w_ack   = bus.ack_riot_i;
        w_rdata = bus.dat_riot_i;
      end
      SEL_ROM: begin
        w_ack   = bus.ack_rom_i;
        w_rdata = bus.dat_rom_i;
      end
      default: begin
        w_ack   = 1'b0;
        w_rdata = '0;
      end
    endcase
  end

  // Request latch, slave handshake, timeout and completion FSM.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_sel      <= SEL_TIA;
      r_cnt      <= '0;
      r_adr      <= '0;
      r_dat      <= '0;
      r_we       <= 1'b0;
      r_stb_tia  <= 1'b0;
      r_stb_riot <= 1'b0;
      r_stb_rom  <= 1'b0;
      r_din      <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A WSYNC stall simply defers the latch; cpu_req stays asserted.
          if (bus.cpu_req && !bus.stall_i) begin
            r_adr      <= bus.cpu_addr[ADDR_WIDTH-1:0];
            r_dat      <= bus.cpu_dout;
            r_we       <= bus.cpu_we;
            r_sel      <= w_sel;
            r_stb_tia  <= (w_sel == SEL_TIA);
            r_stb_riot <= (w_sel == SEL_RIOT);
            r_stb_rom  <= (w_sel == SEL_ROM);
            r_cnt      <= '0;
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_ack) begin
            r_stb_tia  <= 1'b0;
            r_stb_riot <= 1'b0;
            r_stb_rom  <= 1'b0;
            if (!r_we) begin
              r_din <= w_rdata;
            end
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_stb_tia  <= 1'b0;
            r_stb_riot <= 1'b0;
            r_stb_rom  <= 1'b0;
            if (!r_we) begin
              r_din <= DATA_WIDTH'(RD_TIMEOUT_VAL);
            end
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_DONE: begin
          // cpu_req is deliberately not looked at here.
          r_we    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_stb_tia  <= 1'b0;
          r_stb_riot <= 1'b0;
          r_stb_rom  <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.adr_o      = r_adr;
  assign bus.dat_o      = r_dat;
  assign bus.we_o       = r_we;
  assign bus.stb_tia_o  = r_stb_tia;
  assign bus.stb_riot_o = r_stb_riot;
  assign bus.stb_rom_o  = r_stb_rom;
  assign bus.cpu_din    = r_din;
  assign bus.cpu_done   = r_done;
  assign bus.bus_err_o  = r_err;

endmodule

// File: tb/tb_wb_cpu_bridge.sv
// Self-checking bench for wb_cpu_bridge: CPU driver, single-cycle-ack slave
// models, scoreboard on cpu_done, and per-scenario checks.
module tb_wb_cpu_bridge;

  typedef struct {
    logic [7:0] din;
    logic       err;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  wb_cpu_bridge_if #(.ADDR_WIDTH(13), .DATA_WIDTH(8)) bus ();

  wb_cpu_bridge #(.ADDR_WIDTH(13), .DATA_WIDTH(8), .TIMEOUT(16)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  logic [7:0] last_din = 8'h00;

  // Slave models and their controls
  logic m_ack_tia = 1'b0, m_ack_riot = 1'b0, m_ack_rom = 1'b0;
  logic tia_en = 1'b1, riot_en = 1'b1, rom_en = 1'b1;
  logic distract_en = 1'b0, tia_distract = 1'b0;

  // Observation counters (cleared by the scenario tasks)
  int n_stb_tia, n_stb_riot, n_stb_rom, n_done, n_err;
  logic [12:0] cap_adr;
  logic [7:0]  cap_dat;
  logic        cap_we;

  assign bus.ack_tia_i  = m_ack_tia | tia_distract;
  assign bus.ack_riot_i = m_ack_riot;
  assign bus.ack_rom_i  = m_ack_rom;
  assign bus.dat_tia_i  = 8'h80;
  assign bus.dat_riot_i = 8'h5A;
  assign bus.dat_rom_i  = 8'hC3;

  // Each slave registers a one-cycle ack the cycle after its strobe.
  always @(posedge clk_i) begin
    if (rst_i) begin
      m_ack_tia  <= 1'b0;
      m_ack_riot <= 1'b0;
      m_ack_rom  <= 1'b0;
    end else begin
      m_ack_tia  <= bus.stb_tia_o  && !m_ack_tia  && tia_en;
      m_ack_riot <= bus.stb_riot_o && !m_ack_riot && riot_en;
      m_ack_rom  <= bus.stb_rom_o  && !m_ack_rom  && rom_en;
    end
  end

  // Stray TIA acks used while another slave is selected.
  always @(negedge clk_i) begin
    if (distract_en) tia_distract <= ~tia_distract;
    else             tia_distract <= 1'b0;
  end

  // Monitor: strobe accounting, one-hot check and scoreboard on cpu_done.
  always @(negedge clk_i) begin
    if (bus.stb_tia_o)  n_stb_tia++;
    if (bus.stb_riot_o) n_stb_riot++;
    if (bus.stb_rom_o)  n_stb_rom++;
    if (bus.stb_tia_o || bus.stb_riot_o || bus.stb_rom_o) begin
      cap_adr = bus.adr_o;
      cap_dat = bus.dat_o;
      cap_we  = bus.we_o;
    end
    checks++;
    if ((32'(bus.stb_tia_o) + 32'(bus.stb_riot_o) + 32'(bus.stb_rom_o)) > 32'd1) begin
      errors++;
      $display("FAIL stb_onehot got %b%b%b required at most one", bus.stb_tia_o, bus.stb_riot_o, bus.stb_rom_o);
    end
    if (bus.bus_err_o) n_err++;
    if (bus.cpu_done) begin
      exp_t e;
      n_done++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done got cpu_done required none");
      end else begin
        e = exp_q.pop_front();
        if (bus.cpu_din !== e.din) begin
          errors++;
          $display("FAIL sb_cpu_din got %h required %h", bus.cpu_din, e.din);
        end
        checks++;
        if (bus.bus_err_o !== e.err) begin
          errors++;
          $display("FAIL sb_bus_err got %b required %b", bus.bus_err_o, e.err);
        end
      end
    end
  end

  task automatic clear_obs();
    n_stb_tia = 0; n_stb_riot = 0; n_stb_rom = 0; n_done = 0; n_err = 0;
    cap_adr = 13'h0; cap_dat = 8'h00; cap_we = 1'b0;
  endtask

  // Drive one request from a negedge, wait for cpu_done, then drop req.
  // lat counts negedges from the request until cpu_done is seen.
  task automatic run_txn(input logic [15:0] addr, input logic we, input logic [7:0] dout,
                         input logic [7:0] exp_din, input logic exp_err, output int lat);
    bit seen;
    exp_q.push_back('{din: exp_din, err: exp_err});
    @(negedge clk_i);
    clear_obs();
    bus.cpu_req = 1'b1; bus.cpu_addr = addr; bus.cpu_we = we; bus.cpu_dout = dout;
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk_i);
      lat++;
      if (bus.cpu_done) seen = 1'b1;
    end
    bus.cpu_req = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL txn_timeout addr %h got no cpu_done required cpu_done", addr);
    end
    last_din = exp_din;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({bus.stb_tia_o, bus.stb_riot_o, bus.stb_rom_o, bus.we_o, bus.cpu_done, bus.bus_err_o} !== 6'b0 ||
        bus.adr_o !== 13'h0 || bus.dat_o !== 8'h00 || bus.cpu_din !== 8'h00) begin
      errors++;
      $display("FAIL reset_state got adr %h dat %h din %h required all zero", bus.adr_o, bus.dat_o, bus.cpu_din);
    end
  endtask

  task automatic test_tia_write();
    int lat;
    run_txn(16'h0009, 1'b1, 8'h1E, last_din, 1'b0, lat);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL tia_wr_latency got %0d required 3", lat); end
    checks++;
    if (n_stb_tia != 2 || n_stb_riot != 0 || n_stb_rom != 0) begin
      errors++; $display("FAIL tia_wr_stb got %0d/%0d/%0d required 2/0/0", n_stb_tia, n_stb_riot, n_stb_rom);
    end
    checks++;
    if (cap_adr !== 13'h0009 || cap_dat !== 8'h1E || cap_we !== 1'b1) begin
      errors++; $display("FAIL tia_wr_bus got %h %h %b required 0009 1e 1", cap_adr, cap_dat, cap_we);
    end
    checks++;
    if (n_err != 0 || n_done != 1 || bus.we_o !== 1'b0) begin
      errors++; $display("FAIL tia_wr_done got err %0d done %0d we %b required 0 1 0", n_err, n_done, bus.we_o);
    end
  endtask

  task automatic test_tia_read();
    int lat;
    run_txn(16'h000C, 1'b0, 8'h00, 8'h80, 1'b0, lat);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL tia_rd_latency got %0d required 3", lat); end
    checks++;
    if (n_stb_tia != 2 || n_stb_riot != 0 || n_stb_rom != 0 || cap_we !== 1'b0) begin
      errors++; $display("FAIL tia_rd_stb got %0d/%0d/%0d required 2/0/0", n_stb_tia, n_stb_riot, n_stb_rom);
    end
    checks++;
    if (bus.cpu_din !== 8'h80) begin errors++; $display("FAIL tia_rd_hold got %h required 80", bus.cpu_din); end
  endtask

  task automatic test_decode();
    logic [15:0] addrs [4] = '{16'hF123, 16'h0080, 16'h0280, 16'h0040};
    logic [12:0] adrs  [4] = '{13'h1123, 13'h0080, 13'h0280, 13'h0040};
    logic [7:0]  dins  [4] = '{8'hC3, 8'h5A, 8'h5A, 8'h80};
    int          exp_t_n [4] = '{0, 0, 0, 2};
    int          exp_r_n [4] = '{0, 2, 2, 0};
    int          exp_m_n [4] = '{2, 0, 0, 0};
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_txn(addrs[i], 1'b0, 8'h00, dins[i], 1'b0, lat);
      checks++;
      if (n_stb_tia != exp_t_n[i] || n_stb_riot != exp_r_n[i] || n_stb_rom != exp_m_n[i]) begin
        errors++;
        $display("FAIL decode_stb addr %h got %0d/%0d/%0d required %0d/%0d/%0d", addrs[i],
                 n_stb_tia, n_stb_riot, n_stb_rom, exp_t_n[i], exp_r_n[i], exp_m_n[i]);
      end
      checks++;
      if (cap_adr !== adrs[i]) begin
        errors++; $display("FAIL decode_adr addr %h got %h required %h", addrs[i], cap_adr, adrs[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int lat;
    rom_en = 1'b0; distract_en = 1'b1;
    run_txn(16'hF000, 1'b0, 8'h00, 8'hFF, 1'b1, lat);
    rom_en = 1'b1; distract_en = 1'b0;
    checks++;
    if (n_stb_rom != 16 || n_stb_tia != 0) begin
      errors++; $display("FAIL timeout_stb got rom %0d tia %0d required 16 0", n_stb_rom, n_stb_tia);
    end
    checks++;
    if (lat != 17) begin errors++; $display("FAIL timeout_latency got %0d required 17", lat); end
    checks++;
    if (n_err != 1 || n_done != 1) begin
      errors++; $display("FAIL timeout_pulses got err %0d done %0d required 1 1", n_err, n_done);
    end
  endtask

  task automatic test_wsync_stall();
    bit seen = 1'b0;
    exp_q.push_back('{din: last_din, err: 1'b0});
    @(negedge clk_i);
    clear_obs();
    bus.stall_i = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0002; bus.cpu_we = 1'b1; bus.cpu_dout = 8'h00;
    repeat (40) @(negedge clk_i);
    checks++;
    if (n_stb_tia + n_stb_riot + n_stb_rom != 0) begin
      errors++; $display("FAIL stall_hold got %0d strobe cycles required 0", n_stb_tia + n_stb_riot + n_stb_rom);
    end
    bus.stall_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (bus.stb_tia_o !== 1'b1) begin errors++; $display("FAIL stall_release got stb %b required 1", bus.stb_tia_o); end
    bus.stall_i = 1'b1;  // WSYNC takes effect while the write is still in flight
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk_i);
      if (bus.cpu_done) seen = 1'b1;
    end
    bus.cpu_req = 1'b0;
    repeat (3) @(negedge clk_i);
    bus.stall_i = 1'b0;
    checks++;
    if (n_done != 1 || n_stb_tia != 2) begin
      errors++; $display("FAIL stall_done got done %0d stb %0d required 1 2", n_done, n_stb_tia);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit hit = 1'b0;
    int lat;
    tia_en = 1'b0;
    @(negedge clk_i);
    clear_obs();
    bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0010; bus.cpu_we = 1'b0; bus.cpu_dout = 8'h00;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk_i);
      if (bus.stb_tia_o) hit = 1'b1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rst_mid_setup got no stb required stb_tia_o"); end
    rst_i = 1'b1; bus.cpu_req = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({bus.stb_tia_o, bus.stb_riot_o, bus.stb_rom_o, bus.cpu_done, bus.bus_err_o} !== 5'b0) begin
      errors++; $display("FAIL rst_mid_clear got %b required 00000",
                         {bus.stb_tia_o, bus.stb_riot_o, bus.stb_rom_o, bus.cpu_done, bus.bus_err_o});
    end
    @(negedge clk_i);
    rst_i = 1'b0; tia_en = 1'b1; last_din = 8'h00;
    repeat (20) @(negedge clk_i);
    checks++;
    if (n_done != 0 || n_err != 0) begin
      errors++; $display("FAIL rst_mid_pulse got done %0d err %0d required 0 0", n_done, n_err);
    end
    run_txn(16'h0081, 1'b0, 8'h00, 8'h5A, 1'b0, lat);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL rst_mid_recover got %0d required 3", lat); end
  endtask

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_addr = 16'h0; bus.cpu_we = 1'b0; bus.cpu_dout = 8'h0; bus.stall_i = 1'b0;
    clear_obs();
    test_reset();
    test_tia_write();
    test_tia_read();
    test_decode();
    test_timeout();
    test_wsync_stall();
    test_reset_mid_wait();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover got %0d entries required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
